// File: rtl/mux_tt_sweeper.sv
// Truth-table sweeper: steps {A,B,C} through rows 0..7, samples the three mux
// implementations after a settle time and compares their tables to an expected one.
module mux_tt_sweeper #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] exp_table,
    input  logic       out_8,
    input  logic       out_4,
    input  logic       out_2,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_8,
    output logic [7:0] table_4,
    output logic [7:0] table_2,
    output logic       mismatch,
    output logic [7:0] mismatch_mask
);

    localparam int unsigned ROW_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(7);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state;
    logic [ROW_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       exp_q;
    logic [7:0]       t8_nxt, t4_nxt, t2_nxt, mask_nxt;

    // Tables with the current row's sample folded in, so the final compare sees row 7
    always_comb begin
        t8_nxt      = table_8;
        t4_nxt      = table_4;
        t2_nxt      = table_2;
        t8_nxt[idx] = out_8;
        t4_nxt[idx] = out_4;
        t2_nxt[idx] = out_2;
        mask_nxt    = (t8_nxt ^ exp_q) | (t4_nxt ^ exp_q) | (t2_nxt ^ exp_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            exp_q         <= '0;
            {A, B, C}     <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_8       <= '0;
            table_4       <= '0;
            table_2       <= '0;
            mismatch      <= 1'b0;
            mismatch_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    {A, B, C} <= 3'd0;
                    if (start) begin
                        idx           <= '0;
                        cnt           <= '0;
                        exp_q         <= exp_table;
                        table_8       <= '0;
                        table_4       <= '0;
                        table_2       <= '0;
                        mismatch      <= 1'b0;
                        mismatch_mask <= '0;
                        busy          <= 1'b1;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_8 <= t8_nxt;
                    table_4 <= t4_nxt;
                    table_2 <= t2_nxt;
                    if (idx == ROW_LAST) begin
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        mismatch      <= |mask_nxt;
                        mismatch_mask <= mask_nxt;
                        {A, B, C}     <= 3'd0;
                        state         <= DONE;
                    end else begin
                        idx       <= idx + ROW_W'(1);
                        {A, B, C} <= idx + ROW_W'(1);
                        cnt       <= '0;
                        state     <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_tt_sweeper.sv
// Directed bench for mux_tt_sweeper: two instances (settle 1 and 3) driven by a
// behavioural model of the mux implementations, checked with immediate assertions.
module tb_mux_tt_sweeper;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sel;
    logic       mode;
    logic       fault;
    logic [7:0] exp_table;

    logic       a1, b1, c1, busy1, done1, mm1;
    logic [7:0] t8_1, t4_1, t2_1, mask1;
    logic       a3, b3, c3, busy3, done3, mm3;
    logic [7:0] t8_3, t4_3, t2_3, mask3;
    logic       f1, f3;

    logic [2:0] o_abc;
    logic       o_busy, o_done, o_mm;
    logic [7:0] o_t8, o_t4, o_t2, o_mask;

    int passed = 0;
    int total  = 0;

    // Mode 0: XOR3, mode 1: the T2 function (8:1 data hi,hi,lo,lo,lo,hi,hi,lo)
    function automatic logic model_f(input logic [2:0] row, input logic m);
        logic [7:0] t2_data;
        t2_data = 8'b0110_0011;
        return m ? t2_data[row] : ^row;
    endfunction

    assign f1 = model_f({a1, b1, c1}, mode);
    assign f3 = model_f({a3, b3, c3}, mode);

    mux_tt_sweeper #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .start(start && !sel), .exp_table(exp_table),
        .out_8(f1), .out_4(f1), .out_2(fault ? 1'b0 : f1),
        .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
        .table_8(t8_1), .table_4(t4_1), .table_2(t2_1),
        .mismatch(mm1), .mismatch_mask(mask1)
    );

    mux_tt_sweeper #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .start(start && sel), .exp_table(exp_table),
        .out_8(f3), .out_4(f3), .out_2(fault ? 1'b0 : f3),
        .A(a3), .B(b3), .C(c3), .busy(busy3), .done(done3),
        .table_8(t8_3), .table_4(t4_3), .table_2(t2_3),
        .mismatch(mm3), .mismatch_mask(mask3)
    );

    always_comb begin
        o_abc  = sel ? {a3, b3, c3} : {a1, b1, c1};
        o_busy = sel ? busy3 : busy1;
        o_done = sel ? done3 : done1;
        o_mm   = sel ? mm3   : mm1;
        o_t8   = sel ? t8_3  : t8_1;
        o_t4   = sel ? t4_3  : t4_1;
        o_t2   = sel ? t2_3  : t2_1;
        o_mask = sel ? mask3 : mask1;
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_abc"}, 8'(o_abc), 8'h00);
        chk({tag, "_busy"}, 8'(o_busy), 8'h00);
        chk({tag, "_done"}, 8'(o_done), 8'h00);
        chk({tag, "_t8"}, o_t8, 8'h00);
        chk({tag, "_t4"}, o_t4, 8'h00);
        chk({tag, "_t2"}, o_t2, 8'h00);
        chk({tag, "_mm"}, 8'(o_mm), 8'h00);
        chk({tag, "_mask"}, o_mask, 8'h00);
    endtask

    // One full sweep: accept edge, per-edge row/done tracking, final tables
    task automatic run_sweep(input int s, input logic [7:0] ex, input logic [7:0] e8,
                             input logic [7:0] e4, input logic [7:0] e2,
                             input bit hold, input bit chg);
        int n;
        logic [7:0] emask;
        n = 8 * (s + 1);
        emask = (e8 ^ ex) | (e4 ^ ex) | (e2 ^ ex);
        exp_table = ex;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk("accept_busy", 8'(o_busy), 8'h01);
        chk("accept_abc", 8'(o_abc), 8'h00);
        chk("accept_mm", 8'(o_mm), 8'h00);
        for (int k = 1; k <= n; k++) begin
            if (chg && k == n / 2) exp_table = ~ex;
            tick();
            if (k < n) begin
                chk("row_abc", 8'(o_abc), 8'(k / (s + 1)));
                chk("row_done", 8'(o_done), 8'h00);
            end else begin
                chk("end_done", 8'(o_done), 8'h01);
                chk("end_busy", 8'(o_busy), 8'h00);
            end
        end
        chk("table_8", o_t8, e8);
        chk("table_4", o_t4, e4);
        chk("table_2", o_t2, e2);
        chk("mask", o_mask, emask);
        chk("mismatch", 8'(o_mm), 8'(|emask));
        if (!hold) begin
            tick();
            chk("post_done", 8'(o_done), 8'h00);
            chk("post_busy", 8'(o_busy), 8'h00);
            chk("post_hold_t8", o_t8, e8);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        mode = 1'b0;
        fault = 1'b0;
        exp_table = 8'h00;
        tick();
        tick();
        chk_idle_zero("rst1");
        sel = 1'b1;
        #1;
        chk_idle_zero("rst3");
        sel = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk("idle_busy", 8'(o_busy), 8'h00);

        // XOR3 everywhere, matching expectation
        run_sweep(1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0, 1'b0);

        // T2 function
        mode = 1'b1;
        run_sweep(1, 8'h63, 8'h63, 8'h63, 8'h63, 1'b0, 1'b0);
        mode = 1'b0;

        // out_2 stuck at 0
        fault = 1'b1;
        run_sweep(1, 8'h96, 8'h96, 8'h96, 8'h00, 1'b0, 1'b0);
        fault = 1'b0;

        // start held high: single done, relaunch after the IDLE cycle clears tables
        run_sweep(1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b1, 1'b0);
        tick();
        chk("hold_idle_done", 8'(o_done), 8'h00);
        chk("hold_idle_busy", 8'(o_busy), 8'h00);
        chk("hold_idle_t8", o_t8, 8'h96);
        tick();
        chk("relaunch_busy", 8'(o_busy), 8'h01);
        chk("relaunch_t8", o_t8, 8'h00);
        chk("relaunch_mask", o_mask, 8'h00);
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("relaunch_rst_busy", 8'(o_busy), 8'h00);

        // Reset during row 5 settle
        exp_table = 8'h96;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("mid_row5", 8'(o_abc), 8'h05);
        chk("mid_partial_t8", o_t8, 8'h16);
        reset = 1'b1;
        tick();
        chk_idle_zero("midrst");
        tick();
        reset = 1'b0;
        repeat (20) begin
            tick();
            chk("after_rst_done", 8'(o_done), 8'h00);
        end
        chk("after_rst_busy", 8'(o_busy), 8'h00);
        run_sweep(1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0, 1'b0);

        // Settle of 3 cycles, expectation changed mid-sweep
        sel = 1'b1;
        #1;
        run_sweep(3, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_tt_sweeper.md
Name: mux_tt_sweeper

Overview:
- Sequencer that exercises the three mux-based implementations of one 3-input logic function: the 8:1, 4:1 and 2:1 variants.
- Steps the shared select/data inputs {A,B,C} through all 8 combinations and waits a programmable settle time at each.
- Samples the three implementation outputs into 8-bit truth tables and compares each table against an expected table.
- Sits between the lab's switch/button front end and the mux datapath; results drive the LED/report logic.

Parameters:
- SETTLE_CYC, 1, clock cycles {A,B,C} is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; starts one sweep.
- exp_table  input  8  expected truth table; bit i = F({A,B,C}=i); sampled on the start-accept edge.
- out_8  input  1  output of the 8:1-mux implementation.
- out_4  input  1  output of the 4:1-mux implementation.
- out_2  input  1  output of the 2:1-mux implementation.
- A, B, C  output  1 each  registered stimulus; {A,B,C} = row index, A = MSB (A→s[2], B→s[1], C→s[0]).
- busy  output  1  high from the start-accept edge until DONE is entered.
- done  output  1  one-cycle pulse when a sweep completes.
- table_8, table_4, table_2  output  8 each  captured truth tables, bit i = sample at row i.
- mismatch  output  1  any captured table differs from the latched exp_table.
- mismatch_mask  output  8  (table_8^exp)|(table_4^exp)|(table_2^exp).

Behaviour:
- Reset (synchronous, active-high) clears every output and register: A=B=C=0, busy=0, done=0, all tables=0, mismatch=0, mask=0; state returns to IDLE. Reset takes priority over every other event, including mid-sweep. After reset nothing happens until a new start.
- States are IDLE, SETTLE, SAMPLE, DONE. Internal registers: row idx[2:0], settle counter cnt[3:0], exp latch.
- IDLE: {A,B,C}=0. On start=1: idx←0, cnt←0, latch exp_table, clear all three tables plus mismatch/mask, busy←1, go to SETTLE. Results from the previous sweep are held until this edge.
- SETTLE: {A,B,C}=idx. cnt increments each cycle; when cnt==SETTLE_CYC-1, go to SAMPLE.
- SAMPLE: {A,B,C} still = idx. Capture table_x[idx]←out_x for all three.
  - If idx==7: go to DONE.
  - Otherwise: idx←idx+1, cnt←0, go to SETTLE.
- DONE: done=1 for exactly this cycle, busy=0. mismatch and mismatch_mask are valid from this cycle onward and are computed from the final tables. Next state is IDLE unconditionally.
- Timing: each row takes SETTLE_CYC+1 cycles. DONE is entered 8*(SETTLE_CYC+1) edges after the start-accept edge. A new start is accepted at the earliest in the cycle after DONE.
- start while busy, or during DONE, is ignored. No queueing.
- exp_table changes after the start-accept edge do not affect the current sweep.
- idx never wraps: the sweep ends at row 7.
- mismatch and mismatch_mask read 0 while busy. They update only on DONE entry.
- The out_x inputs are sampled only in SAMPLE. They are assumed stable combinationally from A/B/C within SETTLE_CYC cycles.

Test Plan:
- SETTLE_CYC=1; bench models all three outputs as A^B^C; exp_table=0x96; pulse start → rows 0..7 in sequence, done 16 edges after accept, table_8=table_4=table_2=0x96, mismatch=0, mask=0x00.
- Same bench with exp_table=0x63 (T2 function) and models = T2 function (8:1 data hi,hi,lo,lo,lo,hi,hi,lo) → all tables 0x63, mismatch=0.
- Fault injection: out_2 stuck at 0, others XOR3, exp=0x96 → table_2=0x00, mismatch=1, mismatch_mask=0x96; table_8=table_4=0x96.
- start held high through the whole sweep plus a second start pulse at row 3 → exactly one done pulse at edge 16. Held start relaunches in the cycle after done; tables clear on that edge.
- reset asserted during row 5 SETTLE → next edge: all outputs 0, busy=0, no done pulse. Subsequent start gives a full, correct sweep.
- SETTLE_CYC=3 → each {A,B,C} value held 4 cycles, done 32 edges after accept. Change exp_table mid-sweep → no effect on mismatch.
